// File: rtl/vga_reg_viewer.sv
// VGA register viewer: generates VGA timing and draws NUM_REGS registers as rows of scaled
// 8x8 hex glyphs, snapshotted once per frame with per-register change highlighting.
module vga_reg_viewer #(
   parameter int          NUM_REGS      = 4,
   parameter int          REG_WIDTH     = 16,
   parameter int          CLK_DIV       = 4,
   parameter int          H_ACTIVE      = 640,
   parameter int          H_FP          = 16,
   parameter int          H_SYNC        = 96,
   parameter int          H_BP          = 48,
   parameter int          V_ACTIVE      = 480,
   parameter int          V_FP          = 10,
   parameter int          V_SYNC        = 2,
   parameter int          V_BP          = 33,
   parameter int          SYNC_NEG      = 1,
   parameter int          X0            = 32,
   parameter int          Y0            = 32,
   parameter int          SCALE_LOG2    = 1,
   parameter int          HILITE_FRAMES = 60,
   parameter logic [11:0] FG_COLOR      = 12'hFFF,
   parameter logic [11:0] BG_COLOR      = 12'h000,
   parameter logic [11:0] HL_COLOR      = 12'hF00
) (
   input  logic                          CLK100MHZ,
   input  logic                          rst,
   input  logic [NUM_REGS*REG_WIDTH-1:0] reg_values,
   output logic [3:0]                    VGA_R,
   output logic [3:0]                    VGA_G,
   output logic [3:0]                    VGA_B,
   output logic                          VGA_HS,
   output logic                          VGA_VS,
   output logic                          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HLW     = (HILITE_FRAMES > 0) ? $clog2(HILITE_FRAMES + 1) : 1;
   localparam int DIGITS  = REG_WIDTH / 4;
   localparam int CW      = 16;

   localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [HLW-1:0] HL_LOAD = HLW'(HILITE_FRAMES);
   localparam logic [CW-1:0]  X_LO    = CW'(X0);
   localparam logic [CW-1:0]  X_HI    = CW'(X0 + DIGITS * (8 << SCALE_LOG2));
   localparam logic [CW-1:0]  Y_LO    = CW'(Y0);
   localparam logic [CW-1:0]  NREG_W  = CW'(NUM_REGS);
   localparam logic [CW-1:0]  H_ACT_W = CW'(H_ACTIVE);
   localparam logic [CW-1:0]  V_ACT_W = CW'(V_ACTIVE);
   localparam logic [CW-1:0]  HS_LO   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0]  HS_HI   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0]  VS_LO   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0]  VS_HI   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic           SYNC_OFF = (SYNC_NEG != 0) ? 1'b1 : 1'b0;

   // Glyph ROM: row 0 is the most significant byte, bit 7 the leftmost pixel.
   function automatic logic [7:0] glyph_row(input logic [3:0] nib, input logic [2:0] row);
      logic [63:0] g;
      case (nib)
         4'h0:    g = 64'h3C666E7666663C00;
         4'h1:    g = 64'h1838181818187E00;
         4'h2:    g = 64'h3C66060C18307E00;
         4'h3:    g = 64'h3C66061C06663C00;
         4'h4:    g = 64'h0C1C2C4C7E0C0C00;
         4'h5:    g = 64'h7E607C0606663C00;
         4'h6:    g = 64'h1C30607C66663C00;
         4'h7:    g = 64'h7E060C1830303000;
         4'h8:    g = 64'h3C66663C66663C00;
         4'h9:    g = 64'h3C66663E060C3800;
         4'hA:    g = 64'h183C66667E666600;
         4'hB:    g = 64'h7C66667C66667C00;
         4'hC:    g = 64'h3C66606060663C00;
         4'hD:    g = 64'h786C6666666C7800;
         4'hE:    g = 64'h7E60607C60607E00;
         4'hF:    g = 64'h7E60607C60606000;
         default: g = 64'h0000000000000000;
      endcase
      return g[{3'd7 - row, 3'b000} +: 8];
   endfunction

   logic [DW-1:0]        div_q, div_d;
   logic [HW-1:0]        h_q, h_d;
   logic [VW-1:0]        v_q, v_d;
   logic                 pix_ce_s, snap_ev_s, frame_start_q;
   logic [REG_WIDTH-1:0] reg_in_s [NUM_REGS];
   logic [REG_WIDTH-1:0] snap_q [NUM_REGS];
   logic [REG_WIDTH-1:0] snap_d [NUM_REGS];
   logic [HLW-1:0]       hl_q [NUM_REGS];
   logic [HLW-1:0]       hl_d [NUM_REGS];

   logic [CW-1:0] x_s, y_s, xo_s, yo_s, ridx_s, digit_s;
   logic [3:0]    nib_s;
   logic [7:0]    rom_row_s;
   logic          in_cell_s, act_s, hl_sel_s, hs_lvl_s, vs_lvl_s;

   logic [7:0]    glyph_q;
   logic [2:0]    col_q;
   logic          cell_q, hl1_q, act1_q, hs1_q, vs1_q;
   logic [11:0]   rgb_d, rgb_q;
   logic          hs2_q, vs2_q, pix_on_s;

   assign pix_ce_s  = (div_q == DIV_MAX);
   assign snap_ev_s = pix_ce_s && (h_q == H_LAST) && (v_q == V_LAST);

   always_comb begin
      div_d = pix_ce_s ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_ce_s) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end else begin
         h_d = h_q;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= snap_ev_s;
      end
   end

   // Snapshot and highlight update: a change reloads the counter ahead of any decrement.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_in_s[i] = reg_values[i*REG_WIDTH +: REG_WIDTH];
         snap_d[i]   = snap_q[i];
         hl_d[i]     = hl_q[i];
         if (snap_ev_s) begin
            snap_d[i] = reg_in_s[i];
            if (reg_in_s[i] != snap_q[i]) begin
               hl_d[i] = HL_LOAD;
            end else if (hl_q[i] != '0) begin
               hl_d[i] = hl_q[i] - 1'b1;
            end else begin
               hl_d[i] = hl_q[i];
            end
         end else begin
            snap_d[i] = snap_q[i];
         end
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            snap_q[i] <= '0;
            hl_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            snap_q[i] <= snap_d[i];
            hl_q[i]   <= hl_d[i];
         end
      end
   end

   always_comb begin
      x_s       = CW'(h_q);
      y_s       = CW'(v_q);
      xo_s      = x_s - X_LO;
      yo_s      = y_s - Y_LO;
      ridx_s    = yo_s >> (SCALE_LOG2 + 4);
      digit_s   = xo_s >> (SCALE_LOG2 + 3);
      in_cell_s = (x_s >= X_LO) && (x_s < X_HI) && (y_s >= Y_LO) && (ridx_s < NREG_W)
                  && (yo_s[SCALE_LOG2 + 3] == 1'b0);
      act_s     = (x_s < H_ACT_W) && (y_s < V_ACT_W);
      hs_lvl_s  = ((x_s >= HS_LO) && (x_s < HS_HI)) ^ SYNC_OFF;
      vs_lvl_s  = ((y_s >= VS_LO) && (y_s < VS_HI)) ^ SYNC_OFF;
      nib_s     = 4'h0;
      hl_sel_s  = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int d = 0; d < DIGITS; d++) begin
            if ((ridx_s == CW'(r)) && (digit_s == CW'(d))) begin
               nib_s    = snap_q[r][(DIGITS-1-d)*4 +: 4];
               hl_sel_s = (hl_q[r] != '0);
            end else begin
               nib_s    = nib_s;
            end
         end
      end
      rom_row_s = glyph_row(nib_s, yo_s[SCALE_LOG2 +: 3]);
   end

   // Stage 1: glyph row fetch plus the attributes the colour mux needs.
   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         glyph_q <= 8'h00;
         col_q   <= 3'd0;
         cell_q  <= 1'b0;
         hl1_q   <= 1'b0;
         act1_q  <= 1'b0;
         hs1_q   <= SYNC_OFF;
         vs1_q   <= SYNC_OFF;
      end else if (pix_ce_s) begin
         glyph_q <= rom_row_s;
         col_q   <= xo_s[SCALE_LOG2 +: 3];
         cell_q  <= in_cell_s;
         hl1_q   <= hl_sel_s;
         act1_q  <= act_s;
         hs1_q   <= hs_lvl_s;
         vs1_q   <= vs_lvl_s;
      end
   end

   always_comb begin
      pix_on_s = cell_q & glyph_q[3'd7 - col_q];
      if (!act1_q) begin
         rgb_d = 12'h000;
      end else if (pix_on_s) begin
         if (hl1_q) begin
            rgb_d = HL_COLOR;
         end else begin
            rgb_d = FG_COLOR;
         end
      end else begin
         rgb_d = BG_COLOR;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         rgb_q <= 12'h000;
         hs2_q <= SYNC_OFF;
         vs2_q <= SYNC_OFF;
      end else if (pix_ce_s) begin
         rgb_q <= rgb_d;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   assign VGA_R       = rgb_q[11:8];
   assign VGA_G       = rgb_q[7:4];
   assign VGA_B       = rgb_q[3:0];
   assign VGA_HS      = hs2_q;
   assign VGA_VS      = vs2_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_reg_viewer.sv
// Directed bench for vga_reg_viewer on a miniature 40x44 raster: captures whole frames and
// checks hand-computed pixel colours, sync placement, frame period and mid-frame reset.
module tb_vga_reg_viewer;

   localparam int CLK_DIV    = 2;
   localparam int HT         = 40;
   localparam int VT         = 44;
   localparam int NPIX       = HT * VT;
   localparam int FRAME_CLKS = NPIX * CLK_DIV;
   localparam int NFR        = 11;

   typedef struct {
      int          f;
      int          x;
      int          y;
      logic [11:0] exp;
   } pix_vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] reg_values;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, frame_start;

   logic [11:0] fb_rgb [NFR][NPIX];
   logic        fb_hs  [NFR][NPIX];
   logic        fb_vs  [NFR][NPIX];
   pix_vec_t    vecs[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   vga_reg_viewer #(
      .NUM_REGS(2), .REG_WIDTH(8), .CLK_DIV(CLK_DIV),
      .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_NEG(1), .X0(4), .Y0(2), .SCALE_LOG2(1), .HILITE_FRAMES(2),
      .FG_COLOR(12'hFFF), .BG_COLOR(12'h00F), .HL_COLOR(12'hF00)
   ) dut (
      .CLK100MHZ(clk), .rst(rst), .reg_values(reg_values),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .frame_start(frame_start)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int f, input int x, input int y, input logic [11:0] e);
      pix_vec_t v;
      v.f = f; v.x = x; v.y = y; v.exp = e;
      vecs.push_back(v);
   endtask

   // Wait (bounded) for frame_start unless already on it, then record one frame of output.
   // Pixel p appears two pixel slots after its slot, so only pixels 0..NPIX-3 are recorded.
   task automatic capture_frame(input int f, input bit aligned, input bit do_chg,
                                input logic [15:0] chg_val);
      int guard;
      int fs_extra;
      if (!aligned) begin
         guard = 0;
         @(negedge clk);
         while (frame_start !== 1'b1 && guard < FRAME_CLKS) begin
            @(negedge clk);
            guard++;
         end
         check($sformatf("frame_period f%0d", f), guard, 0);
      end
      fs_extra = 0;
      for (int t = 0; t < FRAME_CLKS; t++) begin
         if (t > 0) begin
            @(negedge clk);
            if (frame_start !== 1'b0) fs_extra++;
         end
         if (do_chg && t == FRAME_CLKS / 2) reg_values = chg_val;
         if ((t % CLK_DIV) == 0 && t >= 2 * CLK_DIV) begin
            fb_rgb[f][t/CLK_DIV - 2] = {vga_r, vga_g, vga_b};
            fb_hs[f][t/CLK_DIV - 2]  = vga_hs;
            fb_vs[f][t/CLK_DIV - 2]  = vga_vs;
         end
      end
      check($sformatf("frame_start_single f%0d", f), fs_extra, 0);
   endtask

   initial begin
      int guard;
      int hs_low, hs_first, vs_low, vs_first;

      // {frame, x, y, expected RGB}; BG=00F, FG=FFF, HL=F00, blanking=000
      add_vec(0,  8,  2, 12'hFFF); add_vec(0,  4,  2, 12'h00F); add_vec(0, 10,  6, 12'h00F);
      add_vec(0, 16,  6, 12'hFFF); add_vec(0,  6, 34, 12'h00F); add_vec(0,  8, 34, 12'hFFF);
      add_vec(0, 32,  4, 12'h000);
      add_vec(1,  8,  2, 12'hF00); add_vec(1,  9,  3, 12'hF00); add_vec(1,  4,  2, 12'h00F);
      add_vec(1, 10,  8, 12'hF00); add_vec(1,  8,  8, 12'h00F); add_vec(1, 22,  2, 12'hF00);
      add_vec(1, 20,  2, 12'h00F); add_vec(1, 30,  2, 12'hF00); add_vec(1, 26,  4, 12'h00F);
      add_vec(1, 32,  4, 12'h000); add_vec(1,  8, 18, 12'h00F); add_vec(1,  6, 34, 12'hF00);
      add_vec(1, 14, 36, 12'h00F); add_vec(1, 22, 34, 12'hF00); add_vec(1, 30, 38, 12'h00F);
      add_vec(1, 22, 38, 12'hF00); add_vec(1, 14, 40, 12'h000);
      add_vec(2,  8,  2, 12'hF00); add_vec(2,  6, 34, 12'hF00);
      add_vec(3,  8,  2, 12'hFFF); add_vec(3,  6, 34, 12'hFFF); add_vec(3, 30, 38, 12'h00F);
      add_vec(3, 22, 38, 12'hFFF);
      add_vec(4,  8,  2, 12'hFFF); add_vec(4,  6, 34, 12'h00F); add_vec(4, 10, 34, 12'hF00);
      add_vec(4, 30, 38, 12'hF00); add_vec(4, 22, 38, 12'hF00);
      add_vec(5, 30, 38, 12'hF00); add_vec(5, 22, 38, 12'h00F); add_vec(5,  8, 34, 12'hF00);
      add_vec(5,  6, 34, 12'h00F); add_vec(5,  8,  2, 12'hFFF);
      add_vec(6,  8, 34, 12'hF00); add_vec(6, 30, 38, 12'hF00); add_vec(6,  8,  2, 12'hFFF);
      add_vec(7,  8, 34, 12'hFFF); add_vec(7, 30, 38, 12'hFFF);
      add_vec(9,  8,  2, 12'hFFF); add_vec(9,  8, 34, 12'hFFF); add_vec(9,  4,  2, 12'h00F);
      add_vec(10, 8,  2, 12'hF00); add_vec(10, 8, 34, 12'hF00);

      reg_values = {8'h5E, 8'h3B};
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 1);
      check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check("rst_frame_start", frame_start, 0);

      rst = 1'b0;
      capture_frame(0, 1'b1, 1'b0, 16'h0000);
      capture_frame(1, 1'b0, 1'b0, 16'h0000);
      capture_frame(2, 1'b0, 1'b0, 16'h0000);
      capture_frame(3, 1'b0, 1'b1, {8'hA5, 8'h3B});
      capture_frame(4, 1'b0, 1'b1, {8'hC7, 8'h3B});
      capture_frame(5, 1'b0, 1'b0, 16'h0000);
      capture_frame(6, 1'b0, 1'b0, 16'h0000);
      capture_frame(7, 1'b0, 1'b0, 16'h0000);

      // Mid-frame reset on line 20 while the delayed HS output is low
      guard = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && guard < FRAME_CLKS) begin
         @(negedge clk);
         guard++;
      end
      check("frame_period f8", guard, 0);
      for (int k = 1; k <= (20 * HT + 35 + 2) * CLK_DIV; k++) @(negedge clk);
      check("hs_low_before_rst", vga_hs, 0);
      rst = 1'b1;
      #1;
      check("midrst_hs", vga_hs, 1);
      check("midrst_vs", vga_vs, 1);
      check("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
      check("midrst_frame_start", frame_start, 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      capture_frame(9, 1'b1, 1'b0, 16'h0000);
      capture_frame(10, 1'b0, 1'b0, 16'h0000);

      hs_low = 0; hs_first = -1;
      for (int x = 0; x < HT; x++) begin
         if (fb_hs[1][5*HT + x] == 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = x;
         end
      end
      check("hs_low_pixels", hs_low, 4);
      check("hs_first_x", hs_first, 34);

      vs_low = 0; vs_first = -1;
      for (int p = 0; p < NPIX - 2; p++) begin
         if (fb_vs[1][p] == 1'b0) begin
            vs_low++;
            if (vs_first < 0) vs_first = p;
         end
      end
      check("vs_low_pixels", vs_low, 2 * HT);
      check("vs_first_pixel", vs_first, 41 * HT);

      foreach (vecs[i]) begin
         check($sformatf("pix f%0d (%0d,%0d)", vecs[i].f, vecs[i].x, vecs[i].y),
               fb_rgb[vecs[i].f][vecs[i].y*HT + vecs[i].x], vecs[i].exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
